// File: rtl/alu_issue_ctrl.sv
// Issue/hazard controller in front of the ALU: load scoreboard, operand forwarding, branch stall/flush.
// Optional sticky scoreboard-consistency error output enabled by defining SCOREBOARD_CHECK_EN.
module alu_issue_ctrl #(
    parameter int unsigned cRegAddrWidth = 5,
    parameter int unsigned cMaxLoads     = 2
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iDecValid,
    input  logic [cRegAddrWidth-1:0] iRs1Addr,
    input  logic [cRegAddrWidth-1:0] iRs2Addr,
    input  logic                     iRs1Used,
    input  logic                     iRs2Used,
    input  logic [cRegAddrWidth-1:0] iRdAddr,
    input  logic                     iRdWrite,
    input  logic                     iIsLoad,
    input  logic                     iIsBranch,
    input  logic                     iLoadDone,
    input  logic [cRegAddrWidth-1:0] iLoadDoneAddr,
    input  logic                     iBrResolved,
    input  logic                     iBrTaken,
    output logic                     oIssue,
    output logic                     oStall,
    output logic                     oFlush,
    output logic [1:0]               oFwdSel1,
    output logic [1:0]               oFwdSel2,
`ifdef SCOREBOARD_CHECK_EN
    output logic                     oScbErr,
`endif
    output logic [2:0]               oLoadCnt
);

    localparam int unsigned cNumRegs = 1 << cRegAddrWidth;
    localparam int unsigned cCntW    = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BRWAIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [cNumRegs-1:0]      pending_q, pending_d;
    logic [cCntW-1:0]         cnt_q, cnt_d;
    logic [cRegAddrWidth-1:0] last_rd_q, last_rd_d;
    logic                     last_wr_q, last_wr_d;
    logic                     last_ld_q, last_ld_d;

    logic       run_c;
    logic [2:0] src1_c, src2_c;
    logic       struct_haz_c;
    logic       issue_c;
    logic       ld_inc_c, ld_dec_c;

    // Returns {hazard, fwd_sel} for one source operand.
    function automatic logic [2:0] src_eval(
        input logic                     used,
        input logic [cRegAddrWidth-1:0] addr,
        input logic [cNumRegs-1:0]      pending,
        input logic                     ld_done,
        input logic [cRegAddrWidth-1:0] ld_done_addr,
        input logic                     last_wr,
        input logic                     last_ld,
        input logic [cRegAddrWidth-1:0] last_rd
    );
        logic       active;
        logic [2:0] res;
        res    = 3'b000;
        active = used && (addr != '0);
        if (active && pending[addr]) begin
            if (ld_done && (ld_done_addr == addr)) begin
                res = 3'b010;
            end else begin
                res = 3'b100;
            end
        end else if (active && last_wr && !last_ld && (last_rd == addr)) begin
            res = 3'b001;
        end
        return res;
    endfunction

    assign run_c  = (state_q == ST_RUN) && !iRst;
    assign src1_c = src_eval(iRs1Used, iRs1Addr, pending_q, iLoadDone, iLoadDoneAddr,
                             last_wr_q, last_ld_q, last_rd_q);
    assign src2_c = src_eval(iRs2Used, iRs2Addr, pending_q, iLoadDone, iLoadDoneAddr,
                             last_wr_q, last_ld_q, last_rd_q);

    // Load slot exhaustion (a same-cycle completion frees a slot) and WAW on a pending rd.
    assign struct_haz_c = iIsLoad &&
                          (((cnt_q == cCntW'(cMaxLoads)) && !iLoadDone) || pending_q[iRdAddr]);

    assign issue_c = iDecValid && run_c && !src1_c[2] && !src2_c[2] && !struct_haz_c;

    assign oIssue   = issue_c;
    assign oStall   = !iRst && ((iDecValid && !issue_c) || (state_q != ST_RUN));
    assign oFlush   = !iRst && (state_q == ST_FLUSH);
    assign oFwdSel1 = run_c ? src1_c[1:0] : 2'd0;
    assign oFwdSel2 = run_c ? src2_c[1:0] : 2'd0;
    assign oLoadCnt = cnt_q;

    assign ld_inc_c = issue_c && iIsLoad;
    assign ld_dec_c = iLoadDone && (cnt_q != '0);

    // Scoreboard, load count and last-issue next state.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        last_rd_d = '0;
        last_wr_d = 1'b0;
        last_ld_d = 1'b0;

        if (iLoadDone) begin
            pending_d[iLoadDoneAddr] = 1'b0;
        end
        if (ld_inc_c && (iRdAddr != '0)) begin
            pending_d[iRdAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (ld_inc_c && !ld_dec_c) begin
            cnt_d = cnt_q + cCntW'(1);
        end else if (!ld_inc_c && ld_dec_c) begin
            cnt_d = cnt_q - cCntW'(1);
        end

        if (issue_c) begin
            last_rd_d = iRdAddr;
            last_wr_d = iRdWrite;
            last_ld_d = iIsLoad;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
            cnt_q     <= '0;
            last_rd_q <= '0;
            last_wr_q <= 1'b0;
            last_ld_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            last_wr_q <= last_wr_d;
            last_ld_q <= last_ld_d;
            case (state_q)
                ST_RUN: begin
                    if (issue_c && iIsBranch) begin
                        state_q <= ST_BRWAIT;
                    end
                end
                ST_BRWAIT: begin
                    if (iBrResolved) begin
                        state_q <= iBrTaken ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

`ifdef SCOREBOARD_CHECK_EN
    logic scb_err_q;
    logic scb_evt_c;

    assign scb_evt_c = (iLoadDone && (((iLoadDoneAddr != '0) && !pending_q[iLoadDoneAddr]) ||
                                      (cnt_q == '0))) ||
                       (iBrResolved && (state_q != ST_BRWAIT));

    // Sticky until reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            scb_err_q <= 1'b0;
        end else if (scb_evt_c) begin
            scb_err_q <= 1'b1;
        end
    end

    assign oScbErr = scb_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Table-driven bench for alu_issue_ctrl; expected outputs queued at drive time, compared at negedge.
module tb_alu_issue_ctrl;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rdw;
        logic       ld;
        logic       br;
        logic       ldn;
        logic [4:0] lda;
        logic       brr;
        logic       brt;
        logic       iss;
        logic       stl;
        logic       fl;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [2:0] cnt;
    } vec_t;

    typedef struct packed {
        logic       iss;
        logic       stl;
        logic       fl;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       dec_valid;
    logic [4:0] rs1_addr, rs2_addr, rd_addr, ld_done_addr;
    logic       rs1_used, rs2_used, rd_write, is_load, is_branch;
    logic       ld_done, br_resolved, br_taken;
    logic       issue, stall, flush;
    logic [1:0] fwd1, fwd2;
    logic [2:0] load_cnt;
`ifdef SCOREBOARD_CHECK_EN
    logic       scb_err;
`endif

    int n_vec;
    int n_bad;
    vec_t vecs[$];
    exp_t expq[$];

    alu_issue_ctrl #(.cRegAddrWidth(5), .cMaxLoads(2)) dut (
        .iClk          (clk),
        .iRst          (rst),
        .iDecValid     (dec_valid),
        .iRs1Addr      (rs1_addr),
        .iRs2Addr      (rs2_addr),
        .iRs1Used      (rs1_used),
        .iRs2Used      (rs2_used),
        .iRdAddr       (rd_addr),
        .iRdWrite      (rd_write),
        .iIsLoad       (is_load),
        .iIsBranch     (is_branch),
        .iLoadDone     (ld_done),
        .iLoadDoneAddr (ld_done_addr),
        .iBrResolved   (br_resolved),
        .iBrTaken      (br_taken),
        .oIssue        (issue),
        .oStall        (stall),
        .oFlush        (flush),
        .oFwdSel1      (fwd1),
        .oFwdSel2      (fwd2),
`ifdef SCOREBOARD_CHECK_EN
        .oScbErr       (scb_err),
`endif
        .oLoadCnt      (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(
        input logic rst_i, v, input logic [4:0] rs1, rs2, input logic u1, u2,
        input logic [4:0] rd, input logic rdw, ld, br, ldn, input logic [4:0] lda,
        input logic brr, brt, iss, stl, fl, input logic [1:0] f1, f2, input logic [2:0] cnt);
        vec_t t;
        t.rst = rst_i; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.rd = rd; t.rdw = rdw; t.ld = ld; t.br = br; t.ldn = ldn; t.lda = lda;
        t.brr = brr; t.brt = brt; t.iss = iss; t.stl = stl; t.fl = fl;
        t.f1 = f1; t.f2 = f2; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; dec_valid = t.v; rs1_addr = t.rs1; rs2_addr = t.rs2;
        rs1_used = t.u1; rs2_used = t.u2; rd_addr = t.rd; rd_write = t.rdw;
        is_load = t.ld; is_branch = t.br; ld_done = t.ldn; ld_done_addr = t.lda;
        br_resolved = t.brr; br_taken = t.brt;
    endtask

    task automatic idle_inputs();
        vec_t t;
        t = '{default: '0};
        drive(t);
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e, got;
        @(posedge clk);
        #1;
        drive(t);
        expq.push_back('{iss: t.iss, stl: t.stl, fl: t.fl, f1: t.f1, f2: t.f2, cnt: t.cnt});
        @(negedge clk);
        e   = expq.pop_front();
        got = '{iss: issue, stl: stall, fl: flush, f1: fwd1, f2: fwd2, cnt: load_cnt};
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL vec%0d: got iss=%b stl=%b fl=%b f1=%0d f2=%0d cnt=%0d, want iss=%b stl=%b fl=%b f1=%0d f2=%0d cnt=%0d",
                     idx, got.iss, got.stl, got.fl, got.f1, got.f2, got.cnt,
                     e.iss, e.stl, e.fl, e.f1, e.f2, e.cnt);
        end
    endtask

`ifdef SCOREBOARD_CHECK_EN
    task automatic check_err(input string name, input logic want);
        n_vec++;
        if (scb_err !== want) begin
            n_bad++;
            $display("FAIL %s: oScbErr=%b want %b", name, scb_err, want);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //       rst v rs1 rs2 u1 u2 rd rdw ld br ldn lda brr brt | iss stl fl f1 f2 cnt
        add_vec(1, 1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // load-use: ld x5 ; add x6,x5,x1 waits for writeback
        add_vec(0, 1,  1,  0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  5,  1, 1, 1,  6, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add_vec(0, 1,  5,  1, 1, 1,  6, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add_vec(0, 1,  5,  1, 1, 1,  6, 1, 0, 0, 1, 5, 0, 0,   1, 0, 0, 2, 0, 1);
        add_vec(0, 1,  6,  5, 1, 1,  7, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        // ALU-to-ALU forwarding, gap kills it, x0 never forwards
        add_vec(0, 1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  3,  3, 1, 1,  4, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add_vec(0, 1,  4,  0, 1, 1,  8, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1,  0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  0,  0, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        // max outstanding loads, same-cycle completion frees a slot
        add_vec(0, 1,  1,  0, 1, 0,  7, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  1,  0, 1, 0,  8, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add_vec(0, 1,  1,  0, 1, 0,  9, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 2);
        add_vec(0, 1,  1,  0, 1, 0,  9, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 2);
        add_vec(0, 1,  1,  0, 1, 0,  9, 1, 1, 0, 1, 7, 0, 0,   1, 0, 0, 0, 0, 2);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 9, 0, 0,   0, 0, 0, 0, 0, 2);
        // WAW on pending x8 with a free slot
        add_vec(0, 1,  1,  0, 1, 0,  8, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 8, 0, 0,   0, 0, 0, 0, 0, 1);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // completion at count 0 does not underflow
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // load to x0 takes a slot but never becomes pending
        add_vec(0, 1,  0,  0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  0,  0, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // taken branch resolved three cycles later, then one flush cycle
        add_vec(0, 1,  1,  2, 1, 1,  0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        // not-taken branch: no flush
        add_vec(0, 1, 10,  0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        add_vec(0, 1,  1,  2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        // stray resolve in RUN is ignored
        add_vec(0, 1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 1, 0);
        add_vec(0, 1, 11,  0, 1, 0, 13, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        // reset in BRWAIT with two loads outstanding
        add_vec(0, 1,  1,  0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 1,  1,  0, 1, 0,  6, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add_vec(0, 1,  0,  0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2);
        add_vec(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2);
        add_vec(0, 1,  5,  6, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        add_vec(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end

`ifdef SCOREBOARD_CHECK_EN
        // completion for non-pending x9 sets a sticky error
        check_err("scb_clear_after_rst", 1'b0);
        @(posedge clk); #1;
        idle_inputs(); ld_done = 1'b1; ld_done_addr = 5'd9;
        @(posedge clk); #1;
        idle_inputs(); dec_valid = 1'b1; rs1_addr = 5'd1; rs1_used = 1'b1; rd_addr = 5'd2; rd_write = 1'b1;
        @(negedge clk);
        check_err("scb_set", 1'b1);
        repeat (3) @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check_err("scb_sticky", 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_err("scb_rst", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/hazard controller in front of the ALU execute stage.
- Decides each cycle whether the decoded instruction enters the ALU, or whether decode/fetch stalls.
- Keeps a load scoreboard, generates operand forwarding selects, and sequences branch resolution and flush.
- Sits between the decoder and the ALU; consumes load writeback from the memory stage and branch outcome from the ALU.

Parameters:
- cRegAddrWidth, 5, register address width (32 GPRs).
- cMaxLoads, 2, maximum outstanding loads (1..4).

Ports:
- iClk  in  1  core clock
- iRst  in  1  synchronous active-high reset
- iDecValid  in  1  decoded instruction present
- iRs1Addr  in  5  source 1 address
- iRs2Addr  in  5  source 2 address
- iRs1Used  in  1  instruction reads rs1
- iRs2Used  in  1  instruction reads rs2
- iRdAddr  in  5  destination address
- iRdWrite  in  1  instruction writes rd
- iIsLoad  in  1  opcode is load
- iIsBranch  in  1  opcode is branch
- iLoadDone  in  1  load data written back this cycle
- iLoadDoneAddr  in  5  rd of completing load
- iBrResolved  in  1  ALU reports branch outcome
- iBrTaken  in  1  outcome, valid with iBrResolved
- oIssue  out  1  instruction accepted into ALU this cycle
- oStall  out  1  hold decode/fetch
- oFlush  out  1  squash fetch/decode contents
- oFwdSel1  out  2  rs1 source: 0 regfile, 1 ALU result, 2 load writeback
- oFwdSel2  out  2  rs2 source, same encoding
- oLoadCnt  out  3  outstanding load count

Behaviour:
- Reset:
  - Scoreboard (32 pending bits) cleared; load count 0; state RUN.
  - Last-issue register cleared; all outputs 0.
  - Reset mid-branch or with loads outstanding discards all tracking.
- States and transitions:
  - RUN: normal issue.
  - BRWAIT: entered the cycle after a branch issues. oStall=1 and oIssue=0 until iBrResolved. On resolve: taken -> FLUSH; not taken -> RUN. oStall remains 1 in the resolving cycle.
  - FLUSH: exactly one cycle, with oFlush=1, oStall=1, oIssue=0; then RUN.
  - iBrResolved in RUN/FLUSH: ignored.
- Source hazards, RUN only, per source:
  - Source counts only if used and address != 0.
  - Pending source: hazard, unless iLoadDone=1 and iLoadDoneAddr matches that cycle. Then no hazard and fwdSel=2.
  - Otherwise, if the last issued instruction wrote that rd, was not a load, and issued in the previous cycle: fwdSel=1.
  - Else fwdSel=0.
- Structural hazards:
  - Load with count==cMaxLoads, unless iLoadDone the same cycle.
  - Load whose rd is already pending (WAW).
- Issue decision (combinational): oIssue = iDecValid & state==RUN & no hazard. oStall = iDecValid & ~oIssue, or state != RUN.
- Scoreboard update:
  - Load issue with rd != 0 sets pending[rd].
  - iLoadDone clears pending[iLoadDoneAddr].
  - Set and clear of the same address in one cycle: set wins.
  - x0 is never pending.
  - Loads to x0 still occupy a count slot.
- Load count:
  - +1 on load issue; -1 on iLoadDone; unchanged when both occur.
  - Saturates at 0: iLoadDone with count 0 is ignored.
- Last-issue register: updated on oIssue (rd, rdWrite, isLoad); cleared on cycles without issue.
- All state registered on iClk. Outputs are combinational from current state and inputs, except oLoadCnt, which is registered.

Optional Feature:
- SCOREBOARD_CHECK_EN defined adds output oScbErr (1 bit, sticky, cleared only by iRst). It sets on:
  - iLoadDone for a non-pending, non-zero address;
  - iLoadDone with count 0;
  - iBrResolved outside BRWAIT.
- Undefined: port absent; these events are silently ignored as described above.

Test Plan:
- Load x5, then next cycle add x6,x5,x1 with no iLoadDone -> add stalls (oStall=1, oIssue=0). On the cycle iLoadDone=1 with addr 5, add issues with oFwdSel1=2, and pending[5] clears.
- add x3,x1,x2 issued, then sub x4,x3,x3 back-to-back -> sub issues immediately with oFwdSel1=1 and oFwdSel2=1.
- cMaxLoads=2: three loads to x7,x8,x9 with no completions -> first two issue, oLoadCnt=2, third stalls. iLoadDone addr 7 -> third issues that cycle, and oLoadCnt stays 2.
- Branch issued; iBrResolved=1, iBrTaken=1 three cycles later -> oStall=1 throughout; next cycle oFlush=1 for exactly one cycle; then RUN with oIssue resuming. Same sequence with iBrTaken=0 -> no oFlush.
- iRst asserted during BRWAIT with 2 loads outstanding -> next cycle state RUN, oLoadCnt=0, all pending bits clear, and a dependent add on x5 issues with oFwdSel1=0.
- With SCOREBOARD_CHECK_EN: iLoadDone addr 9 while not pending -> oScbErr=1 next cycle and held through later traffic until iRst.
